// File: rtl/serial_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_if
// Request/result bundle between a requester and the bit-serial adder.
//
// Signals
//   start     requester -> adder   request, sampled only while busy=0
//   a_in      requester -> adder   operand A (WIDTH bits)
//   b_in      requester -> adder   operand B (WIDTH bits)
//   busy      adder -> requester   addition in progress
//   done      adder -> requester   one-cycle pulse, result valid
//   sum_out   adder -> requester   (A+B) mod 2^WIDTH, held until next done
//   cout_out  adder -> requester   carry out of bit WIDTH-1, held with sum_out
//
// Modports
//   master : requester side
//   slave  : adder side
// ---------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;

  modport master (
    output start, a_in, b_in,
    input  busy, done, sum_out, cout_out
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, sum_out, cout_out
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder. Two WIDTH-bit operands are captured on an accepted start
// and fed LSB-first, one bit per clock, through a full-add slice built from
// two half-add steps. The carry lives in a register between bits and the sum
// bits are collected MSB-in in a shift register. After WIDTH bits the result
// and final carry are published and done pulses for one cycle.
//
// Parameters
//   WIDTH   operand/result width, 2..32
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     serial_adder_ctrl_if.slave: start/a_in/b_in in,
//           busy/done/sum_out/cout_out out (all outputs registered)
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_adder_ctrl_if.slave   bus
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_res;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum_out;
  logic               r_cout_out;

  // Full-add slice as two half-add steps on the current LSBs.
  logic             w_ha1_s;
  logic             w_ha1_c;
  logic             w_sum_bit;
  logic             w_ha2_c;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_ha1_s     = r_a_sh[0] ^ r_b_sh[0];
  assign w_ha1_c     = r_a_sh[0] & r_b_sh[0];
  assign w_sum_bit   = w_ha1_s ^ r_carry;
  assign w_ha2_c     = w_ha1_s & r_carry;
  assign w_carry_nxt = w_ha1_c | w_ha2_c;

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the sum has
  // travelled down to bit 0 of the result.
  assign w_res_nxt = {w_sum_bit, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_res      <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sum_out  <= '0;
      r_cout_out <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless re-asserted below.
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a_sh  <= bus.a_in;
            r_b_sh  <= bus.b_in;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_carry <= w_carry_nxt;
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_res   <= w_res_nxt;
          if (r_cnt == CNT_LAST) begin
            // Last bit: publish result, counter parks at 0 instead of wrapping.
            r_sum_out  <= w_res_nxt;
            r_cout_out <= w_carry_nxt;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_state    <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.sum_out  = r_sum_out;
  assign bus.cout_out = r_cout_out;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Directed checks of serial_adder_ctrl at WIDTH=8 plus an exhaustive sweep of
// a WIDTH=4 instance sharing the same clock and reset.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  serial_adder_ctrl_if #(.WIDTH(8)) u_if8 ();
  serial_adder_ctrl_if #(.WIDTH(4)) u_if4 ();

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if8.slave)
  );

  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called right after the start edge (T0+1). Returns cycles until done is
  // seen and how many of those cycles had busy high. Optionally disturbs
  // start/a_in at cycle disturb_at to prove they are ignored during RUN.
  task automatic wait_done8(input string tag, input int disturb_at,
                            output int cyc, output int nbusy);
    cyc   = 0;
    nbusy = 0;
    while (!u_if8.done && cyc < 30) begin
      if (u_if8.busy) nbusy++;
      if (cyc == disturb_at) begin
        u_if8.start = 1'b1;
        u_if8.a_in  = 8'h00;
      end else if (cyc == disturb_at + 1) begin
        u_if8.start = 1'b0;
      end
      tick();
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(u_if8.done), 64'd1);
    check({tag, "_busy_in_done"}, 64'(u_if8.busy), 64'd0);
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp_sum, input logic exp_cout, input int disturb_at);
    int cyc;
    int nbusy;
    u_if8.a_in  = a;
    u_if8.b_in  = b;
    u_if8.start = 1'b1;
    tick();
    u_if8.start = 1'b0;
    wait_done8(tag, disturb_at, cyc, nbusy);
    check({tag, "_latency"}, 64'(cyc), 64'd8);
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'd8);
    check({tag, "_sum"}, 64'(u_if8.sum_out), 64'(exp_sum));
    check({tag, "_cout"}, 64'(u_if8.cout_out), 64'(exp_cout));
    $display("op %s: a=0x%02h b=0x%02h sum=0x%02h cout=%0d latency=%0d",
             tag, a, b, u_if8.sum_out, u_if8.cout_out, cyc);
    tick();
    check({tag, "_done_fall"}, 64'(u_if8.done), 64'd0);
  endtask

  initial begin
    int cyc;
    int nbusy;
    int gap;
    int bad4;
    n_checks = 0;
    n_fail   = 0;
    rst_n       = 1'b0;
    u_if8.start = 1'b0;
    u_if8.a_in  = '0;
    u_if8.b_in  = '0;
    u_if4.start = 1'b0;
    u_if4.a_in  = '0;
    u_if4.b_in  = '0;

    // Reset state
    tick();
    tick();
    check("rst_busy", 64'(u_if8.busy), 64'd0);
    check("rst_done", 64'(u_if8.done), 64'd0);
    check("rst_sum",  64'(u_if8.sum_out), 64'd0);
    check("rst_cout", 64'(u_if8.cout_out), 64'd0);
    rst_n = 1'b1;
    tick();
    $display("reset released");

    // 1. add zero
    op8("zero", 8'h00, 8'h00, 8'h00, 1'b0, -1);
    // 2. full carry ripple
    op8("ripple", 8'hFF, 8'h01, 8'h00, 1'b1, -1);
    // 3. start and a_in disturbed mid-RUN
    op8("ignore", 8'hA5, 8'h5A, 8'hFF, 1'b0, 3);
    for (int i = 0; i < 10; i++) begin
      if (u_if8.done || u_if8.busy) begin
        check("ignore_no_extra_op", 64'({u_if8.busy, u_if8.done}), 64'd0);
        break;
      end
      tick();
    end
    check("ignore_idle_after", 64'({u_if8.busy, u_if8.done}), 64'd0);
    check("ignore_sum_held", 64'(u_if8.sum_out), 64'hFF);

    // 4. reset abort after 3 bits
    u_if8.a_in  = 8'h33;
    u_if8.b_in  = 8'h11;
    u_if8.start = 1'b1;
    tick();
    u_if8.start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_busy_before", 64'(u_if8.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(u_if8.busy), 64'd0);
    check("abort_done", 64'(u_if8.done), 64'd0);
    check("abort_sum",  64'(u_if8.sum_out), 64'd0);
    check("abort_cout", 64'(u_if8.cout_out), 64'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (u_if8.done) check("abort_no_done", 64'(u_if8.done), 64'd0);
    end
    rst_n = 1'b1;
    tick();
    $display("op abort: reset applied mid-RUN, outputs cleared");
    op8("after_abort", 8'h80, 8'h80, 8'h00, 1'b1, -1);

    // 5. back-to-back with start held in the done cycle
    u_if8.a_in  = 8'h10;
    u_if8.b_in  = 8'h01;
    u_if8.start = 1'b1;
    tick();
    u_if8.start = 1'b0;
    wait_done8("b2b1", -1, cyc, nbusy);
    check("b2b1_sum",  64'(u_if8.sum_out), 64'h11);
    check("b2b1_cout", 64'(u_if8.cout_out), 64'd0);
    $display("op b2b1: a=0x10 b=0x01 sum=0x%02h cout=%0d", u_if8.sum_out, u_if8.cout_out);
    u_if8.a_in  = 8'hF0;
    u_if8.b_in  = 8'h20;
    u_if8.start = 1'b1;
    tick();
    u_if8.start = 1'b0;
    check("b2b2_accepted", 64'(u_if8.busy), 64'd1);
    check("b2b2_sum_held", 64'(u_if8.sum_out), 64'h11);
    wait_done8("b2b2", -1, cyc, nbusy);
    gap = cyc + 1;
    check("b2b_gap", 64'(gap), 64'd9);
    check("b2b2_sum",  64'(u_if8.sum_out), 64'h10);
    check("b2b2_cout", 64'(u_if8.cout_out), 64'd1);
    $display("op b2b2: a=0xF0 b=0x20 sum=0x%02h cout=%0d gap=%0d",
             u_if8.sum_out, u_if8.cout_out, gap);
    tick();

    // 6. exhaustive WIDTH=4
    bad4 = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int w;
        logic [4:0] exp5;
        exp5 = 5'(a) + 5'(b);
        u_if4.a_in  = 4'(a);
        u_if4.b_in  = 4'(b);
        u_if4.start = 1'b1;
        tick();
        u_if4.start = 1'b0;
        w = 0;
        while (!u_if4.done && w < 20) begin
          tick();
          w++;
        end
        check("w4_latency", 64'(w), 64'd4);
        check("w4_result", 64'({u_if4.cout_out, u_if4.sum_out}), 64'(exp5));
        if ({u_if4.cout_out, u_if4.sum_out} !== exp5) bad4++;
        tick();
      end
    end
    $display("op w4_sweep: 256 pairs, %0d wrong", bad4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
